// File: rtl/dft_frame_sequencer.sv
// Frame controller for the DFT engine: buffers a frame, bursts it in, starts the engine, streams results.
// Optional wait-state watchdog enabled by defining DFT_SEQ_WATCHDOG_EN.
module dft_frame_sequencer #(
  parameter int DATA_W  = 32,
  parameter int N_PTS   = 128,
  parameter int IDX_W   = 7,
  parameter int TMO_CYC = 65535
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic [DATA_W-1:0] dft_time_data,
  output logic              dft_start,
  output logic [IDX_W-1:0]  dft_harm,
  output logic [IDX_W-1:0]  dft_ampl_idx,
  input  logic              dft_done,
  input  logic [DATA_W-1:0] dft_cos,
  input  logic [DATA_W-1:0] dft_sin,
  input  logic [DATA_W-1:0] dft_ampl,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_cos,
  output logic [DATA_W-1:0] m_sin,
  output logic [DATA_W-1:0] m_ampl,
  output logic [IDX_W-1:0]  m_index,
  output logic              m_last,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    ST_FILL,
    ST_BURST,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_READ
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PTS - 1);

  state_t            state_reg;
  logic [IDX_W-1:0]  wp_reg;
  logic [IDX_W-1:0]  rp_reg;
  logic [IDX_W-1:0]  bin_reg;
  logic              cap_done_reg;
  logic [DATA_W-1:0] buf_mem [N_PTS];
  logic              wr_en;
  logic              wd_expire;

  assign wr_en        = n_reset && (state_reg == ST_FILL) && s_valid && s_ready;
  assign dft_harm     = bin_reg;
  assign dft_ampl_idx = bin_reg;

  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[wp_reg] <= s_data;
  end

`ifdef DFT_SEQ_WATCHDOG_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] wd_cnt_reg;
  logic             err_reg;
  logic             in_wait;
  logic             wd_restart;

  assign in_wait    = (state_reg == ST_WAIT_BUSY) || (state_reg == ST_WAIT_DONE);
  // The WAIT_BUSY -> WAIT_DONE hop restarts the count for the second wait.
  assign wd_restart = (state_reg == ST_WAIT_BUSY) && !dft_done;
  assign wd_expire  = in_wait && (wd_cnt_reg == TMO_W'(TMO_CYC));
  assign err        = err_reg;

  always_ff @(posedge clk) begin
    if (!n_reset || !in_wait || wd_restart) wd_cnt_reg <= '0;
    else if (!wd_expire)                    wd_cnt_reg <= wd_cnt_reg + 1'b1;
    if (!n_reset)       err_reg <= 1'b0;
    else if (wd_expire) err_reg <= 1'b1;
  end
`else
  assign wd_expire = 1'b0;
  assign err       = 1'b0;
  if (TMO_CYC < 1) begin : g_tmo_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_reg     <= ST_FILL;
      wp_reg        <= '0;
      rp_reg        <= '0;
      bin_reg       <= '0;
      cap_done_reg  <= 1'b0;
      s_ready       <= 1'b1;
      dft_time_data <= '0;
      dft_start     <= 1'b0;
      m_valid       <= 1'b0;
      m_cos         <= '0;
      m_sin         <= '0;
      m_ampl        <= '0;
      m_index       <= '0;
      m_last        <= 1'b0;
      busy          <= 1'b0;
    end else begin
      dft_start <= 1'b0;
      if (wd_expire) begin
        state_reg <= ST_FILL;
        wp_reg    <= '0;
        s_ready   <= 1'b1;
        busy      <= 1'b0;
      end else begin
        case (state_reg)
          ST_FILL: begin
            if (s_valid && s_ready) begin
              wp_reg <= wp_reg + 1'b1;
              if (wp_reg == LAST_IDX) begin
                // rp is 0 here: prefetch entry 0 so the burst starts in the first BURST cycle.
                s_ready       <= 1'b0;
                busy          <= 1'b1;
                dft_time_data <= buf_mem[rp_reg];
                rp_reg        <= rp_reg + 1'b1;
                state_reg     <= ST_BURST;
              end
            end
          end
          ST_BURST: begin
            if (rp_reg == '0) begin
              dft_time_data <= '0;
              dft_start     <= 1'b1;
              state_reg     <= ST_START;
            end else begin
              dft_time_data <= buf_mem[rp_reg];
              rp_reg        <= rp_reg + 1'b1;
            end
          end
          ST_START: begin
            state_reg <= ST_WAIT_BUSY;
          end
          ST_WAIT_BUSY: begin
            if (!dft_done) state_reg <= ST_WAIT_DONE;
          end
          ST_WAIT_DONE: begin
            if (dft_done) begin
              bin_reg      <= '0;
              cap_done_reg <= 1'b0;
              state_reg    <= ST_READ;
            end
          end
          ST_READ: begin
            if (!cap_done_reg && (!m_valid || m_ready)) begin
              m_cos   <= dft_cos;
              m_sin   <= dft_sin;
              m_ampl  <= dft_ampl;
              m_index <= bin_reg;
              m_last  <= (bin_reg == LAST_IDX);
              m_valid <= 1'b1;
              bin_reg <= bin_reg + 1'b1;
              if (bin_reg == LAST_IDX) cap_done_reg <= 1'b1;
            end else if (m_valid && m_ready && m_last) begin
              m_valid   <= 1'b0;
              m_last    <= 1'b0;
              wp_reg    <= '0;
              s_ready   <= 1'b1;
              busy      <= 1'b0;
              state_reg <= ST_FILL;
            end
          end
          default: state_reg <= ST_FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dft_frame_sequencer.sv
// Scoreboard bench for dft_frame_sequencer: directed frames, engine model, burst/result monitors.
module tb_dft_frame_sequencer;
  localparam int DW = 32;
  localparam int NP = 128;
  localparam int IW = 7;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic [DW-1:0] dft_time_data;
  logic          dft_start;
  logic [IW-1:0] dft_harm;
  logic [IW-1:0] dft_ampl_idx;
  logic          dft_done;
  logic [DW-1:0] dft_cos, dft_sin, dft_ampl;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_cos, m_sin, m_ampl;
  logic [IW-1:0] m_index;
  logic          m_last;
  logic          busy;
  logic          err;

  dft_frame_sequencer #(.DATA_W(DW), .N_PTS(NP), .IDX_W(IW), .TMO_CYC(100)) dut (
    .clk(clk), .n_reset(n_reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .dft_time_data(dft_time_data), .dft_start(dft_start),
    .dft_harm(dft_harm), .dft_ampl_idx(dft_ampl_idx), .dft_done(dft_done),
    .dft_cos(dft_cos), .dft_sin(dft_sin), .dft_ampl(dft_ampl),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_cos(m_cos), .m_sin(m_sin), .m_ampl(m_ampl),
    .m_index(m_index), .m_last(m_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0]  tq[$];
  logic [127:0] rq[$];

  int start_cnt      = 0;
  int start_cyc      = 0;
  int burst_last_cyc = -10;
  int burst_run      = 0;
  int beats          = 0;
  int first_beat_cyc = 0;
  int last_beat_cyc  = 0;
  int rdy_mode       = 0;
  int rdy_ph         = 0;
  bit engine_en      = 1'b1;
  bit hold_pend      = 1'b0;
  logic [127:0] hold_val;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [127:0] pack(input logic v, input logic l, input logic [IW-1:0] i,
                                        input logic [31:0] c, input logic [31:0] s,
                                        input logic [31:0] a);
    return {23'd0, v, l, i, c, s, a};
  endfunction

  // Engine model: results are combinational functions of the read indices.
  assign dft_cos  = {25'd0, dft_harm};
  assign dft_sin  = 32'h100 + {25'd0, dft_harm};
  assign dft_ampl = 32'h200 + {25'd0, dft_ampl_idx};

  initial begin
    dft_done = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (dft_start === 1'b1 && engine_en) begin
        @(posedge clk); #1;
        dft_done = 1'b0;
        repeat (500) @(posedge clk);
        #1 dft_done = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) m_ready = 1'b1;
    else begin
      m_ready = (rdy_ph == 0);
      rdy_ph  = (rdy_ph == 2) ? 0 : rdy_ph + 1;
    end
  end

  // Burst monitor: every nonzero word on the time-data port is a burst word.
  always @(negedge clk) begin
    logic [31:0] exp_w;
    if (n_reset === 1'b1 && dft_time_data !== '0) begin
      if (cyc == burst_last_cyc + 1) burst_run++;
      else burst_run = 1;
      burst_last_cyc = cyc;
      if (tq.size() == 0) chk("burst_extra", {96'd0, dft_time_data}, 128'd0);
      else begin
        exp_w = tq.pop_front();
        chk("burst_word", {96'd0, dft_time_data}, {96'd0, exp_w});
      end
    end
  end

  always @(negedge clk) begin
    if (dft_start === 1'b1) begin
      start_cnt++;
      start_cyc = cyc;
      $display("start pulse at cycle %0d", cyc);
      chk("start_gap", 128'(cyc - burst_last_cyc), 128'd1);
      chk("burst_len", 128'(burst_run), 128'(NP));
    end
  end

  // Result monitor: pops expected beat on each handshake, checks hold on stalls.
  always @(negedge clk) begin
    logic [127:0] cur;
    cur = pack(m_valid, m_last, m_index, m_cos, m_sin, m_ampl);
    if (hold_pend) begin
      chk("hold_stable", cur, hold_val);
      hold_pend = 1'b0;
    end
    if (n_reset === 1'b1 && m_valid === 1'b1) begin
      if (m_ready === 1'b1) begin
        beats++;
        if (beats == 1) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        $display("beat idx=%0d last=%0d cos=%h sin=%h ampl=%h", m_index, m_last, m_cos, m_sin, m_ampl);
        if (rq.size() == 0) chk("beat_extra", cur, 128'd0);
        else chk("beat", cur, rq.pop_front());
      end else begin
        hold_pend = 1'b1;
        hold_val  = cur;
      end
    end
  end

  task automatic send_frame(input logic [31:0] base, input bit push_res);
    int n;
    for (int i = 0; i < NP; i++) tq.push_back(base + 32'(i));
    if (push_res)
      for (int k = 0; k < NP; k++)
        rq.push_back(pack(1'b1, k == NP - 1, 7'(k), 32'(k), 32'(k + 256), 32'(k + 512)));
    $display("frame base=%h", base);
    for (int i = 0; i < NP; i++) begin
      s_valid = 1'b1;
      s_data  = base + 32'(i);
      n = 0;
      while (s_ready !== 1'b1 && n < 3000) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 3000) begin
        chk("s_ready_timeout", {127'd0, s_ready}, 128'd1);
        break;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int lim);
    int n = 0;
    while (busy !== 1'b0 && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, {127'd0, busy}, 128'd0);
  endtask

  initial begin
    int n;
    int starts_before;
    n_reset = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", {127'd0, s_ready}, 128'd1);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_m_valid", {127'd0, m_valid}, 128'd0);
    chk("rst_err", {127'd0, err}, 128'd0);
    chk("rst_time_data", {96'd0, dft_time_data}, 128'd0);
    chk("rst_harm", {121'd0, dft_harm}, 128'd0);
    chk("rst_m_index", {121'd0, m_index}, 128'd0);
    chk("rst_no_start", 128'(start_cnt), 128'd0);
    n_reset = 1'b1;
    s_valid = 1'b0;
    @(posedge clk); #1;

    // Frame A: sink always ready, back-to-back results.
    beats = 0;
    send_frame(32'h3F800000, 1'b1);
    chk("a_s_ready_low", {127'd0, s_ready}, 128'd0);
    chk("a_busy_burst", {127'd0, busy}, 128'd1);
    wait_idle("a_idle", 3000);
    chk("a_beats", 128'(beats), 128'(NP));
    chk("a_throughput", 128'(last_beat_cyc - first_beat_cyc), 128'(NP - 1));
    chk("a_starts", 128'(start_cnt), 128'd1);
    chk("a_ready_again", {127'd0, s_ready}, 128'd1);

    // Frame B: sink ready pattern 1,0,0.
    beats = 0;
    rdy_mode = 1;
    send_frame(32'h40000000, 1'b1);
    wait_idle("b_idle", 4000);
    rdy_mode = 0;
    chk("b_beats", 128'(beats), 128'(NP));
    chk("b_starts", 128'(start_cnt), 128'd2);

    // Frame C: reset during readout after 40 accepted bins.
    beats = 0;
    send_frame(32'h40400000, 1'b1);
    n = 0;
    while (beats < 40 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("c_reach_40", 128'(beats), 128'd40);
    n_reset = 1'b0;
    @(posedge clk); #1;
    chk("c_rst_m_valid", {127'd0, m_valid}, 128'd0);
    chk("c_rst_busy", {127'd0, busy}, 128'd0);
    chk("c_rst_s_ready", {127'd0, s_ready}, 128'd1);
    @(posedge clk); #1;
    n_reset = 1'b1;
    rq.delete();
    starts_before = start_cnt;

    // Frame D: fresh frame after the abort.
    beats = 0;
    send_frame(32'h40800000, 1'b1);
    wait_idle("d_idle", 3000);
    chk("d_beats", 128'(beats), 128'(NP));
    chk("d_new_start", 128'(start_cnt), 128'(starts_before + 1));

    // Frame E: engine never reports busy.
    engine_en = 1'b0;
    beats = 0;
    starts_before = start_cnt;
    send_frame(32'h40C00000, 1'b0);
    n = 0;
    while (start_cnt == starts_before && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("e_start", 128'(start_cnt), 128'(starts_before + 1));
    repeat (300) @(posedge clk);
    #1;
`ifdef DFT_SEQ_WATCHDOG_EN
    chk("e_err_set", {127'd0, err}, 128'd1);
    chk("e_back_fill", {127'd0, busy}, 128'd0);
    chk("e_s_ready", {127'd0, s_ready}, 128'd1);
`else
    chk("e_err_zero", {127'd0, err}, 128'd0);
    chk("e_still_busy", {127'd0, busy}, 128'd1);
`endif
    chk("e_no_results", 128'(beats), 128'd0);
    chk("tq_empty", 128'(tq.size()), 128'd0);
    chk("rq_empty", 128'(rq.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dft_frame_sequencer.md
Name: dft_frame_sequencer

Overview:
Frame-level controller for the 128-point DFT engine. It buffers one frame of 32-bit time samples from a valid/ready source and bursts them into the engine's shift-in port on consecutive cycles. It then pulses the engine start, tracks its done handshake, and steps the harmonic/amplitude read indices to stream cos/sin/amplitude results to a valid/ready sink. It sits between the sample source (ADC/FIFO side) and the DFT core, and is the only agent driving the core's start and index inputs.

Parameters:
DATA_W, 32, sample and result word width (IEEE-754 single)
N_PTS, 128, samples per frame and the number of result bins read out
IDX_W, 7, index width, equal to log2(N_PTS)
TMO_CYC, 65535, watchdog limit in cycles per wait state (used only with the optional feature)

Ports:
clk  in  1  rising-edge clock
n_reset  in  1  synchronous reset, active low
s_valid  in  1  sample valid
s_ready  out  1  sample ready
s_data  in  DATA_W  sample word
dft_time_data  out  DATA_W  word shifted into the DFT engine every clock
dft_start  out  1  one-cycle start pulse to the engine
dft_harm  out  IDX_W  harmonic read index (cos/sin)
dft_ampl_idx  out  IDX_W  amplitude read index
dft_done  in  1  engine idle/complete: 1 = idle, 0 = computing
dft_cos, dft_sin, dft_ampl  in  DATA_W each  engine results, combinational on the indices
m_valid  out  1  result valid
m_ready  in  1  result ready
m_cos, m_sin, m_ampl  out  DATA_W each  registered result words
m_index  out  IDX_W  bin number of the current result
m_last  out  1  asserted with bin N_PTS-1
busy  out  1  high in every state except FILL
err  out  1  sticky watchdog error flag

Behaviour:
- Reset: n_reset is sampled only on the rising edge of clk. State goes to FILL. All counters clear to 0.
- Reset values: s_ready=1, dft_time_data=0, dft_start=0, dft_harm=0, dft_ampl_idx=0, m_valid=0, m_cos/m_sin/m_ampl=0, m_index=0, m_last=0, busy=0, err=0.
- Storage: internal N_PTS x DATA_W buffer with write pointer wp and read pointer rp.
- FILL: s_ready = (wp < N_PTS).
  - Each s_valid&&s_ready writes buf[wp] and increments wp.
  - On the write of entry N_PTS-1, s_ready drops in the next cycle and the FSM moves to BURST.
- BURST: for exactly N_PTS consecutive cycles, dft_time_data = buf[rp] and rp increments each cycle. No stalls.
  - First-written sample goes out first, so it ends up at the engine's index 0.
  - When rp wraps from N_PTS-1 to 0, the FSM goes to START.
  - dft_time_data holds 0 in all states other than BURST.
- START: dft_start=1 for exactly one cycle, then WAIT_BUSY.
- WAIT_BUSY: stay until dft_done==0, then WAIT_DONE. This guards against the engine still reporting idle in the cycle after start.
- WAIT_DONE: stay until dft_done==1. Then set bin k=0 and go to READ.
- READ: dft_harm = dft_ampl_idx = k.
  - When m_valid==0 or (m_valid&&m_ready): capture dft_cos/dft_sin/dft_ampl into m_*, set m_index=k and m_last=(k==N_PTS-1), set m_valid=1, and increment k.
  - Once bin N_PTS-1 has been captured, stop capturing.
  - When the sink accepts the last bin (m_valid&&m_ready&&m_last): m_valid drops next cycle, wp clears, FSM returns to FILL.
- Throughput: one result per cycle while m_ready is held high; the first m_valid appears 1 cycle after entering READ.
- m_* outputs stay stable while m_valid&&!m_ready (standard valid/ready hold rule).
- Boundaries:
  - s_valid is ignored outside FILL (s_ready=0).
  - dft_done glitches in START are ignored.
  - Reset mid-frame or mid-readout discards buffer and results. m_valid drops on the reset edge, and the engine is not re-started until a full new frame has been filled.
  - err is not cleared by a new frame; only reset clears it.

Optional Feature:
DFT_SEQ_WATCHDOG_EN
- Defined: a cycle counter runs in WAIT_BUSY and WAIT_DONE and clears on each state entry.
  - If it reaches TMO_CYC, err is set to 1 (sticky), wp clears and the FSM returns to FILL.
  - No results are emitted for the aborted frame.
- Not defined: no counter is present, err is tied to 0, and the wait states can last indefinitely.

Test Plan:
- Reset with n_reset=0 for 3 cycles while s_valid=1 -> s_ready=1, busy=0, m_valid=0, dft_start never pulses, and no write is taken during reset.
- Feed samples 0x3F800000+i (i=0..127) with s_valid=1 continuously -> s_ready low after the 128th beat; dft_time_data shows the same 128 words in order on 128 consecutive cycles; dft_start is a single pulse on the next cycle.
- Engine model drops dft_done 2 cycles after start, raises it 500 cycles later, and returns dft_cos=k, dft_sin=k+0x100, dft_ampl=k+0x200; m_ready=1 -> 128 consecutive beats with m_index 0..127, m_last only on beat 127, and the next frame accepted afterward.
- Same frame with m_ready toggling 1,0,0 repeatedly -> no lost or duplicated bins, and m_* held stable during the zero-ready cycles.
- Assert n_reset=0 during READ at bin 40 -> m_valid=0 and busy=0 after the edge; the next 128 samples produce a fresh start pulse.
- With DFT_SEQ_WATCHDOG_EN, TMO_CYC=100 and dft_done held at 1 after start -> err=1 at cycle 100 of WAIT_BUSY, FSM back in FILL, no m_valid. Without the macro, err stays 0 and busy stays 1.
